fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined CPU. Holds the program counter, issues instruction-memory requests, and produces the IF/ID pipeline register. It drives `pc_plus4` into the 4:1 next-PC selector and takes that selector's 32-bit output back on `next_pc`. It also absorbs hazard-unit stalls and branch/jump flushes.

## Interface
- `DATA_WIDTH`, 32, width of PC, addresses and instruction words.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  single clock, rising-edge.
- `clrn`  in  1  asynchronous, active-low reset.
- `next_pc`  in  DATA_WIDTH  selected next PC from the next-PC selector.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `flush`  in  1  control redirect: squash IF/ID and the in-flight fetch, load `next_pc`.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  DATA_WIDTH  fetch address; stable while `imem_req` is high and `imem_ready` is low.
- `imem_ready`  in  1  response valid; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  DATA_WIDTH  fetched instruction.
- `pc`  out  DATA_WIDTH  current PC register.
- `pc_plus4`  out  DATA_WIDTH  `pc + 4`, combinational.
- `if_valid`  out  1  IF/ID holds a real instruction.
- `if_inst`  out  DATA_WIDTH  IF/ID instruction.
- `if_pc`  out  DATA_WIDTH  IF/ID instruction address.
- `stall_cycles`  out  32  fetch stall counter (see Configuration).

## Operation
- States: `S_FETCH`, `S_HOLD`, `S_DROP`.
- Reset (`clrn`=0, asynchronous) sets:
  - `pc`=`RESET_PC`, state `S_FETCH`, `imem_req`=0 while in reset.
  - `imem_addr`=`RESET_PC`.
  - `if_valid`=0, `if_inst`=0, `if_pc`=0, `stall_cycles`=0.
- `S_FETCH`: `imem_req`=1, `imem_addr`=registered request address.
  - `imem_ready` and not `stall`: IF/ID loads {1, `imem_rdata`, request address}; `pc` loads `next_pc`; the request address loads `next_pc`.
  - `imem_ready` and `stall`: the instruction goes into the hold buffer and the state moves to `S_HOLD`. IF/ID and `pc` are unchanged.
  - No `imem_ready` and not `stall`: IF/ID loads a bubble (`if_valid`=0).
  - No `imem_ready` and `stall`: everything holds.
- `S_HOLD`: `imem_req`=0. On not `stall`: IF/ID loads the hold buffer, `pc` and the request address load `next_pc`, next state is `S_FETCH`.
- `flush` has priority over `stall` and over `imem_ready`:
  - IF/ID is cleared (`if_valid`=0).
  - `pc` and the request address load `next_pc`.
  - The hold buffer is discarded.
  - If a request is outstanding without `imem_ready` in the same cycle, the next state is `S_DROP`. Otherwise it is `S_FETCH`.
- `S_DROP`: `imem_req`=1 with the old address held. When `imem_ready` arrives, the response is discarded and the state moves to `S_FETCH` at the new address. A further `flush` in `S_DROP` updates the target only.
- Arithmetic: `pc_plus4` wraps modulo 2^DATA_WIDTH (32'hFFFF_FFFC gives 0). No alignment checks are made.

## Timing
- Fetch latency is 1 cycle minimum. A response in cycle N is visible on `if_*` in cycle N+1.
- With zero-wait memory and no hazards, throughput is 1 instruction per cycle.
- The first request is issued in the first cycle after `clrn` deasserts.
- `next_pc` is sampled only on the edge where `pc` updates. It may be combinationally derived from `pc_plus4`.
- Reset asserted mid-fetch drops the request immediately. Memory must tolerate an abandoned request.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `stall_cycles` increments, wrapping, on every cycle where `imem_req`=1 and `imem_ready`=0.
  - It also increments on every cycle in `S_HOLD`.
  - It clears on reset.
- Not defined: `stall_cycles` is tied to 0 and no counter logic is built.

## Structure
- Shared CPU package holds:
  - the `fetch_state_t` enum (`S_FETCH`, `S_HOLD`, `S_DROP`);
  - `RESET_PC_DEFAULT`;
  - the `INST_NOP` constant (32'h0000_0000).
- Natural sub-module: `if_id_reg`, the IF/ID pipeline register with enable and synchronous clear.

## Test plan
- Reset release with zero-wait memory and `next_pc`=`pc_plus4`: `imem_addr` reads 0, 4, 8 on consecutive cycles; `if_pc` trails by one cycle with `if_valid`=1.
- `imem_ready` delayed 2 cycles at pc=8: `imem_addr` holds 8 and `if_valid`=0 for 2 cycles; `stall_cycles`=2 with the macro enabled, 0 without it.
- `stall` high for 3 cycles while the response 32'h0123_4567 arrives: state goes to `S_HOLD`, `if_*` is frozen and `pc` holds. After release, `if_inst`=32'h0123_4567.
- `flush` with `next_pc`=32'h100 while a request is pending: next state is `S_DROP` and the late response is discarded. The next `if_pc`=32'h100, with no stale instruction.
- `flush` and `stall` in the same cycle: `if_valid`=0 and `pc`=`next_pc`.
- `pc`=32'hFFFF_FFFC: `pc_plus4`=0. `clrn` pulsed mid-`S_HOLD`: `pc`=`RESET_PC` and `if_valid`=0 asynchronously.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: FSM encoding, reset PC and NOP encoding.
// Latency: none; this package holds only types and constants.
// Backpressure: not applicable.
package fetch_stage_pkg;

    // Fetch FSM: issuing requests, parked on a stalled response, or draining an abandoned request
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: valid bit, instruction word and instruction address.
// Latency: 1 cycle from d_* to q_*.
// Backpressure: en low holds contents; clr (priority over en) loads a NOP bubble.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  d_valid,
    input  logic [DATA_WIDTH-1:0] d_inst,
    input  logic [DATA_WIDTH-1:0] d_pc,
    output logic                  q_valid,
    output logic [DATA_WIDTH-1:0] q_inst,
    output logic [DATA_WIDTH-1:0] q_pc
);

    // Pipeline register with synchronous squash taking precedence over load
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q_valid <= 1'b0;
            q_inst  <= DATA_WIDTH'(INST_NOP);
            q_pc    <= '0;
        end else if (clr) begin
            q_valid <= 1'b0;
            q_inst  <= DATA_WIDTH'(INST_NOP);
            q_pc    <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_inst  <= d_inst;
            q_pc    <= d_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem request/response handling, IF/ID register; optional FETCH_STALL_CNT_EN counter.
// Latency: response in cycle N appears on if_* in cycle N+1; 1 instruction/cycle with zero-wait memory.
// Backpressure: stall parks a returned word in a hold buffer (no new request); flush squashes and drains any in-flight request.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                     DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic [DATA_WIDTH-1:0] next_pc,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_inst,
    output logic [DATA_WIDTH-1:0] if_pc,
    output logic [31:0]           stall_cycles
);

    fetch_state_t          state, state_nxt;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] hold_q;

    // FSM-decoded strobes
    logic req_active;    // a request is on the bus this cycle (ignoring reset)
    logic fetch_take;    // response accepted straight into IF/ID
    logic fetch_park;    // response arrived under stall, park it
    logic fetch_miss;    // no response and not stalled: insert bubble
    logic hold_release;  // parked instruction moves into IF/ID
    logic drop_done;     // abandoned request finally answered
    logic go_drop;       // flush while a request is still unanswered

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next-state logic; flush overrides stall and the response
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = go_drop ? S_DROP : S_FETCH;
        end else begin
            case (state)
                S_FETCH: if (imem_ready && stall) state_nxt = S_HOLD;
                S_HOLD:  if (!stall)              state_nxt = S_FETCH;
                S_DROP:  if (imem_ready)          state_nxt = S_FETCH;
                default:                          state_nxt = S_FETCH;
            endcase
        end
    end

    // Output / control decode; the request is dropped the instant reset asserts
    always_comb begin
        req_active   = (state != S_HOLD);
        imem_req     = req_active && clrn;
        fetch_take   = (state == S_FETCH) &&  imem_ready && !stall;
        fetch_park   = (state == S_FETCH) &&  imem_ready &&  stall;
        fetch_miss   = (state == S_FETCH) && !imem_ready && !stall;
        hold_release = (state == S_HOLD)  && !stall;
        drop_done    = (state == S_DROP)  &&  imem_ready;
        go_drop      = flush && req_active && !imem_ready;
    end

    // PC register: follows the selected next PC whenever an instruction retires from fetch or on redirect
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                                   pc_q <= RESET_PC;
        else if (flush || fetch_take || hold_release) pc_q <= next_pc;
    end

    // Request address: stays on the abandoned address while draining, then picks up the redirect target held in pc
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            req_addr_q <= RESET_PC;
        end else if (flush) begin
            if (!go_drop) req_addr_q <= next_pc;
        end else if (fetch_take || hold_release) begin
            req_addr_q <= next_pc;
        end else if (drop_done) begin
            req_addr_q <= pc_q;
        end
    end

    // Hold buffer captures a response that arrives while decode is stalled
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                    hold_q <= '0;
        else if (fetch_park && !flush) hold_q <= imem_rdata;
    end

    if_id_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_id (
        .clk     (clk),
        .clrn    (clrn),
        .en      (fetch_take || hold_release),
        .clr     (flush || fetch_miss),
        .d_valid (1'b1),
        .d_inst  ((state == S_HOLD) ? hold_q : imem_rdata),
        .d_pc    (req_addr_q),
        .q_valid (if_valid),
        .q_inst  (if_inst),
        .q_pc    (if_pc)
    );

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles waiting on memory or parked behind a decode stall
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            stall_cnt_q <= '0;
        else if ((imem_req && !imem_ready) || (state == S_HOLD))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 32'd0;
`endif

    assign imem_addr = req_addr_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + DATA_WIDTH'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic against a behavioural model.
// Latency: model predicts outputs one clock after each applied input vector.
// Backpressure: bench drives stall, flush and imem_ready directly.
module tb_fetch_stage;

    logic        clk;
    logic        clrn;
    logic [31:0] next_pc;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: pc, an optional abandoned request (ghost), an optional parked word, and IF/ID contents
    logic [31:0] m_pc;
    logic        m_ghost;
    logic [31:0] m_ghost_addr;
    logic        m_held;
    logic [31:0] m_held_inst;
    logic        m_ifv;
    logic [31:0] m_ifi;
    logic [31:0] m_ifp;
    logic [31:0] m_cnt;

    fetch_stage dut (
        .clk          (clk),
        .clrn         (clrn),
        .next_pc      (next_pc),
        .stall        (stall),
        .flush        (flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .if_valid     (if_valid),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef FETCH_STALL_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ghost = 1'b0; m_ghost_addr = 32'h0;
        m_held = 1'b0; m_held_inst = 32'h0;
        m_ifv = 1'b0; m_ifi = 32'h0; m_ifp = 32'h0; m_cnt = 32'h0;
    endtask

    task automatic model_step(input logic st, input logic fl, input logic rdy,
                              input logic [31:0] rd, input logic [31:0] npc);
        logic busy;
        busy = !m_held;
        if ((busy && !rdy) || m_held) m_cnt = m_cnt + 32'd1;
        if (fl) begin
            m_ifv = 1'b0;
            if (busy && !rdy) begin
                if (!m_ghost) m_ghost_addr = m_pc;
                m_ghost = 1'b1;
            end else begin
                m_ghost = 1'b0;
            end
            m_held = 1'b0;
            m_pc = npc;
        end else if (m_ghost) begin
            if (rdy) m_ghost = 1'b0;
        end else if (m_held) begin
            if (!st) begin
                m_ifv = 1'b1; m_ifi = m_held_inst; m_ifp = m_pc;
                m_held = 1'b0; m_pc = npc;
            end
        end else if (rdy) begin
            if (st) begin
                m_held = 1'b1; m_held_inst = rd;
            end else begin
                m_ifv = 1'b1; m_ifi = rd; m_ifp = m_pc; m_pc = npc;
            end
        end else if (!st) begin
            m_ifv = 1'b0;
        end
    endtask

    // One clock: apply inputs, check combinational outputs, advance model, check registered outputs
    task automatic cycle(input logic st, input logic fl, input logic rdy,
                         input logic [31:0] rd, input logic [31:0] npc);
        stall = st; flush = fl; imem_ready = rdy; imem_rdata = rd; next_pc = npc;
        #2;
        chk("imem_req", {31'b0, imem_req}, {31'b0, !m_held});
        chk("imem_addr", imem_addr, m_ghost ? m_ghost_addr : m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        model_step(st, fl, rdy, rd, npc);
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_ifv});
        if (m_ifv) begin
            chk("if_inst", if_inst, m_ifi);
            chk("if_pc", if_pc, m_ifp);
        end
        chk("stall_cycles", stall_cycles, exp_cnt());
    endtask

    initial begin
        logic [31:0] tgt;
        logic        rst, rfl, rrd;
        clrn = 1'b0; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0;
        imem_rdata = 32'h0; next_pc = 32'h0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;

        // Reset state
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_cnt", stall_cycles, 32'h0);
        clrn = 1'b1;

        // Zero-wait sequential fetch: addresses 0, 4 then 8
        repeat (2) cycle(1'b0, 1'b0, 1'b1, $urandom, m_pc + 32'd4);

        // Memory waits two cycles at pc=8
        repeat (2) cycle(1'b0, 1'b0, 1'b0, $urandom, m_pc + 32'd4);
        chk("wait_addr", imem_addr, 32'h8);
`ifdef FETCH_STALL_CNT_EN
        chk("wait_cnt", stall_cycles, 32'd2);
`else
        chk("wait_cnt", stall_cycles, 32'd0);
`endif
        cycle(1'b0, 1'b0, 1'b1, $urandom, m_pc + 32'd4);

        // Stall while a response arrives, then release
        cycle(1'b1, 1'b0, 1'b1, 32'h0123_4567, m_pc + 32'd4);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, $urandom, m_pc + 32'd4);
        cycle(1'b0, 1'b0, 1'b0, $urandom, m_pc + 32'd4);
        chk("hold_inst", if_inst, 32'h0123_4567);

        // Flush to 0x100 while the request is pending; late response must vanish
        cycle(1'b0, 1'b0, 1'b0, $urandom, m_pc + 32'd4);
        cycle(1'b0, 1'b1, 1'b0, $urandom, 32'h100);
        cycle(1'b0, 1'b0, 1'b0, $urandom, m_pc + 32'd4);
        cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, m_pc + 32'd4);
        cycle(1'b0, 1'b0, 1'b1, $urandom, m_pc + 32'd4);
        chk("redirect_if_pc", if_pc, 32'h100);

        // Flush together with stall
        tgt = 32'h0000_0200;
        cycle(1'b1, 1'b1, 1'b1, $urandom, tgt);
        chk("flush_stall_valid", {31'b0, if_valid}, 32'd0);
        chk("flush_stall_pc", pc, tgt);

        // PC wrap
        cycle(1'b0, 1'b1, 1'b1, $urandom, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, $urandom, m_pc + 32'd4);

        // Asynchronous reset mid-hold
        cycle(1'b1, 1'b0, 1'b1, $urandom, m_pc + 32'd4);
        #2 clrn = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        model_reset();
        #2 clrn = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 3) == 0);
            rfl = ($urandom_range(0, 7) == 0);
            rrd = ($urandom_range(0, 2) != 0);
            if (rfl || $urandom_range(0, 9) == 0)
                tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            else
                tgt = m_pc + 32'd4;
            cycle(rst, rfl, rrd, $urandom, tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
